// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, receive-FIFO entry layout, default depth.
package uart_pkg;

    localparam int BYTE_WIDTH    = 8;
    localparam int RX_FIFO_DEPTH = 8;

    typedef struct packed {
        logic                  error;
        logic [BYTE_WIDTH-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Receive FIFO storage: DEPTH x rx_entry_t registers, one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH      = RX_FIFO_DEPTH,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  rx_entry_t             wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output rx_entry_t             rdata
);

    rx_entry_t mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// Receive-side FIFO behind the UART receiver. Pushes one entry per rising
// edge of data_is_valid, presents the head over valid/ready, and flags drops.
// Optional build macro: RX_FIFO_DROP_ERRORED_EN discards parity-errored bytes
// instead of storing them, and ties out_error low.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = RX_FIFO_DEPTH,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] received_data,
    input  logic                  data_is_valid,
    input  logic                  rx_error,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  out_error,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic                  dv_q;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  full;
    logic                  do_write;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    rx_entry_t             wr_entry;
    rx_entry_t             rd_entry;

    // data_is_valid is a level; only its rising edge requests a push.
    assign push_req = data_is_valid & ~dv_q;

`ifdef RX_FIFO_DROP_ERRORED_EN
    // Errored bytes vanish here, so they neither occupy space nor count as drops.
    assign push_ok = push_req & ~rx_error;
`else
    assign push_ok = push_req;
`endif

    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_write  = push_ok & (~full | pop);
    assign drop      = push_ok & full & ~pop;

    assign wr_entry.error = rx_error;
    assign wr_entry.data  = received_data;

    rx_fifo_mem #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    // Head entry is gated to zero when empty so stale storage never leaks out.
    assign out_data = out_valid ? rd_entry.data : '0;
`ifdef RX_FIFO_DROP_ERRORED_EN
    assign out_error = 1'b0;
`else
    assign out_error = out_valid & rd_entry.error;
`endif

    // Edge-detect register for data_is_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            dv_q <= 1'b0;
        end else begin
            dv_q <= data_is_valid;
        end
    end

    // Pointers wrap naturally; full/empty come from count, not pointer compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: net change of push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
